// File: rtl/testdrive_virtual_slave_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// testdrive_virtual_slave_arbiter_pkg
// Shared types and constants for the virtual slave arbiter.
//   state_t        : arbiter FSM states (2 bits)
//   C_DATA_BITS    : slave data width
//   cnt_width()    : width of the read-latency down-counter
// -----------------------------------------------------------------------------
package testdrive_virtual_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int C_DATA_BITS = 32;

  // Counter must hold the value C_READ_LATENCY itself.
  function automatic int cnt_width(input int read_latency);
    int w;
    w = $clog2(read_latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/testdrive_virtual_slave_arbiter_rr.sv
// -----------------------------------------------------------------------------
// testdrive_rr_arbiter
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index with highest priority this round
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester
// -----------------------------------------------------------------------------
module testdrive_rr_arbiter #(
  parameter int C_PORTS = 4,
  parameter int C_IDX_W = (C_PORTS > 1) ? $clog2(C_PORTS) : 1
) (
  input  logic [C_PORTS-1:0] req,
  input  logic [C_IDX_W-1:0] ptr,
  output logic [C_PORTS-1:0] grant,
  output logic [C_IDX_W-1:0] grant_idx
);

  logic found;
  int   idx;

  // Scan upward from ptr with wrap; the first set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < C_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= C_PORTS) idx = idx - C_PORTS;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx[C_IDX_W-1:0];
      end
    end
    grant[grant_idx] = found;
  end

endmodule

// File: rtl/testdrive_virtual_slave_arbiter.sv
// -----------------------------------------------------------------------------
// testdrive_virtual_slave_arbiter
// Shares one register-style slave port between C_PORTS requesters with
// round-robin arbitration and one transaction in flight.
//   CLK, nRST              : clock, async active-low reset
//   REQ/REQ_WE/REQ_ADDR/REQ_WDATA : per-requester request, op, address, data
//   ACK, ACK_RDATA         : one-hot completion pulse and read data
//   BUSY                   : FSM not in IDLE
//   WE/WADDR/WDATA         : slave write strobe, address, data
//   RE/RADDR, RDATA        : slave read strobe, address, returned data
// -----------------------------------------------------------------------------
module testdrive_virtual_slave_arbiter
  import testdrive_virtual_slave_arbiter_pkg::*;
#(
  parameter int C_PORTS        = 4,
  parameter int C_ADDR_BITS    = 10,
  parameter int C_READ_LATENCY = 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [C_PORTS-1:0]             REQ,
  input  logic [C_PORTS-1:0]             REQ_WE,
  input  logic [C_PORTS*C_ADDR_BITS-1:0] REQ_ADDR,
  input  logic [C_PORTS*C_DATA_BITS-1:0] REQ_WDATA,
  output logic [C_PORTS-1:0]             ACK,
  output logic [C_DATA_BITS-1:0]         ACK_RDATA,
  output logic                           BUSY,
  output logic                           WE,
  output logic [C_ADDR_BITS-1:0]         WADDR,
  output logic [C_DATA_BITS-1:0]         WDATA,
  output logic                           RE,
  output logic [C_ADDR_BITS-1:0]         RADDR,
  input  logic [C_DATA_BITS-1:0]         RDATA
);

  localparam int C_IDX_W = (C_PORTS > 1) ? $clog2(C_PORTS) : 1;
  localparam int C_CNT_W = cnt_width(C_READ_LATENCY);

  state_t               state_reg;
  logic [C_IDX_W-1:0]   ptr_reg;
  logic [C_IDX_W-1:0]   gidx_reg;
  logic                 op_we_reg;
  logic [C_CNT_W-1:0]   cnt_reg;
  logic [C_PORTS-1:0]   ack_reg;
  logic [C_DATA_BITS-1:0] ack_rdata_reg;
  logic                 busy_reg;
  logic                 we_reg;
  logic                 re_reg;
  logic [C_ADDR_BITS-1:0] waddr_reg;
  logic [C_ADDR_BITS-1:0] raddr_reg;
  logic [C_DATA_BITS-1:0] wdata_reg;

  logic [C_PORTS-1:0]   arb_grant;
  logic [C_IDX_W-1:0]   arb_idx;
  logic [C_IDX_W-1:0]   ptr_next;

  testdrive_rr_arbiter #(
    .C_PORTS (C_PORTS),
    .C_IDX_W (C_IDX_W)
  ) u_rr (
    .req       (REQ),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign ptr_next = (gidx_reg == C_IDX_W'(C_PORTS - 1)) ? '0 : gidx_reg + 1'b1;

  // Strobes and ACK are set on the edge entering ISSUE/DONE so that every
  // output is a flop and a write completes in the cycle after REQ is sampled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gidx_reg      <= '0;
      op_we_reg     <= 1'b0;
      cnt_reg       <= '0;
      ack_reg       <= '0;
      ack_rdata_reg <= '0;
      busy_reg      <= 1'b0;
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      waddr_reg     <= '0;
      raddr_reg     <= '0;
      wdata_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|REQ) begin
            gidx_reg  <= arb_idx;
            op_we_reg <= REQ_WE[arb_idx];
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
            if (REQ_WE[arb_idx]) begin
              we_reg    <= 1'b1;
              waddr_reg <= REQ_ADDR[int'(arb_idx)*C_ADDR_BITS +: C_ADDR_BITS];
              wdata_reg <= REQ_WDATA[int'(arb_idx)*C_DATA_BITS +: C_DATA_BITS];
              ack_reg   <= arb_grant;
            end else begin
              re_reg    <= 1'b1;
              raddr_reg <= REQ_ADDR[int'(arb_idx)*C_ADDR_BITS +: C_ADDR_BITS];
            end
          end
        end
        ISSUE: begin
          we_reg  <= 1'b0;
          re_reg  <= 1'b0;
          ack_reg <= '0;
          ptr_reg <= ptr_next;
          if (op_we_reg) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= C_CNT_W'(C_READ_LATENCY);
            state_reg <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Counter reaches 1 in the cycle RDATA is valid.
          if (cnt_reg == C_CNT_W'(1)) begin
            ack_rdata_reg <= RDATA;
            ack_reg       <= {{(C_PORTS-1){1'b0}}, 1'b1} << gidx_reg;
            cnt_reg       <= '0;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ACK       = ack_reg;
  assign ACK_RDATA = ack_rdata_reg;
  assign BUSY      = busy_reg;
  assign WE        = we_reg;
  assign WADDR     = waddr_reg;
  assign WDATA     = wdata_reg;
  assign RE        = re_reg;
  assign RADDR     = raddr_reg;

endmodule

// File: tb/tb_testdrive_virtual_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_testdrive_virtual_slave_arbiter
// Directed bench: one instance with read latency 1, one with read latency 3.
// Cycle 0 is the cycle in which REQ is first presented and sampled.
// -----------------------------------------------------------------------------
module tb_testdrive_virtual_slave_arbiter;

  localparam int P = 4;
  localparam int A = 10;

  logic clk;
  logic n_rst;

  // latency-1 instance
  logic [P-1:0]   req, req_we, ack;
  logic [P*A-1:0] req_addr;
  logic [P*32-1:0] req_wdata;
  logic [31:0]    ack_rdata, wdata, rdata;
  logic           busy, we, re;
  logic [A-1:0]   waddr, raddr;

  // latency-3 instance
  logic [P-1:0]   req3, req_we3, ack3;
  logic [P*A-1:0] req_addr3;
  logic [P*32-1:0] req_wdata3;
  logic [31:0]    ack_rdata3, wdata3, rdata3;
  logic           busy3, we3, re3;
  logic [A-1:0]   waddr3, raddr3;

  int tests_run    = 0;
  int tests_failed = 0;

  testdrive_virtual_slave_arbiter #(.C_PORTS(P), .C_ADDR_BITS(A), .C_READ_LATENCY(1)) dut (
    .CLK(clk), .nRST(n_rst), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .ACK(ack), .ACK_RDATA(ack_rdata), .BUSY(busy),
    .WE(we), .WADDR(waddr), .WDATA(wdata), .RE(re), .RADDR(raddr), .RDATA(rdata)
  );

  testdrive_virtual_slave_arbiter #(.C_PORTS(P), .C_ADDR_BITS(A), .C_READ_LATENCY(3)) dut3 (
    .CLK(clk), .nRST(n_rst), .REQ(req3), .REQ_WE(req_we3), .REQ_ADDR(req_addr3),
    .REQ_WDATA(req_wdata3), .ACK(ack3), .ACK_RDATA(ack_rdata3), .BUSY(busy3),
    .WE(we3), .WADDR(waddr3), .WDATA(wdata3), .RE(re3), .RADDR(raddr3), .RDATA(rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to the next cycle and settle just after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Wait (bounded) for a nonzero ACK on the chosen instance; returns 0 on timeout.
  task automatic wait_ack(input int which, output logic [P-1:0] a);
    a = '0;
    for (int n = 0; n < 20; n++) begin
      next_cycle();
      if (which == 1 && ack != '0) begin a = ack; break; end
      if (which == 3 && ack3 != '0) begin a = ack3; break; end
    end
  endtask

  task automatic set_port(input int p, input logic is_we, input logic [A-1:0] ad,
                          input logic [31:0] d);
    req_we[p]             = is_we;
    req_addr[p*A +: A]    = ad;
    req_wdata[p*32 +: 32] = d;
  endtask

  logic [P-1:0] a;
  int           exp_order [6] = '{0, 1, 2, 3, 0, 1};
  int           extra;

  initial begin
    n_rst = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; rdata = 32'h0BAD_0BAD;
    req3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0; rdata3 = 32'h0BAD_0BAD;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_we_re", 64'({we, re}), 64'h0);
    check("rst_ack_rdata", 64'(ack_rdata), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // ---------------- single write, port 2 ----------------
    next_cycle();                               // cycle 0
    set_port(2, 1'b1, 10'h15, 32'hDEADBEEF);
    req = 4'b0100;
    next_cycle();                               // cycle 1
    check("wr_we", 64'(we), 64'h1);
    check("wr_waddr", 64'(waddr), 64'h15);
    check("wr_wdata", 64'(wdata), 64'hDEADBEEF);
    check("wr_ack", 64'(ack), 64'b0100);
    check("wr_re", 64'(re), 64'h0);
    req = '0;
    next_cycle();                               // cycle 2
    check("wr_done_ack", 64'(ack), 64'h0);
    check("wr_done_we", 64'(we), 64'h0);
    check("wr_done_busy", 64'(busy), 64'h0);

    // ---------------- single read L=1, port 0 (pointer now 3) ----------------
    next_cycle();                               // cycle 0
    set_port(0, 1'b0, 10'h3, 32'h0);
    req = 4'b0001;
    next_cycle();                               // cycle 1
    check("rd1_re", 64'(re), 64'h1);
    check("rd1_raddr", 64'(raddr), 64'h3);
    check("rd1_busy_c1", 64'(busy), 64'h1);
    check("rd1_ack_c1", 64'(ack), 64'h0);
    next_cycle();                               // cycle 2
    rdata = 32'h12345678;
    check("rd1_re_c2", 64'(re), 64'h0);
    check("rd1_busy_c2", 64'(busy), 64'h1);
    next_cycle();                               // cycle 3
    rdata = 32'h0BAD_0BAD;
    check("rd1_ack", 64'(ack), 64'b0001);
    check("rd1_ack_rdata", 64'(ack_rdata), 64'h12345678);
    check("rd1_busy_c3", 64'(busy), 64'h1);
    req = '0;
    next_cycle();                               // cycle 4
    check("rd1_ack_c4", 64'(ack), 64'h0);
    check("rd1_busy_c4", 64'(busy), 64'h0);

    // ---------------- write leaves ACK_RDATA / RADDR alone (pointer 1) ----------------
    set_port(1, 1'b1, 10'h2A, 32'h0000_5555);
    req = 4'b0010;
    next_cycle();
    check("wr2_ack", 64'(ack), 64'b0010);
    check("wr2_waddr", 64'(waddr), 64'h2A);
    check("wr2_ack_rdata_kept", 64'(ack_rdata), 64'h12345678);
    check("wr2_raddr_kept", 64'(raddr), 64'h3);
    req = '0;
    next_cycle();

    // ---------------- round-robin fairness from pointer 0 ----------------
    do_reset();
    for (int p = 0; p < P; p++) set_port(p, 1'b1, A'(p + 8), 32'h100 + 32'(p));
    next_cycle();
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_ack(1, a);
      check($sformatf("rr_ack_%0d", n), 64'(a), 64'(1) << exp_order[n]);
      check($sformatf("rr_waddr_%0d", n), 64'(waddr), 64'(exp_order[n] + 8));
      check($sformatf("rr_wdata_%0d", n), 64'(wdata), 64'(32'h100 + 32'(exp_order[n])));
    end
    req = '0;
    next_cycle();

    // ---------------- pointer skip: pointer 1, ports 0 and 3 ----------------
    do_reset();
    next_cycle();
    req = 4'b0001;
    wait_ack(1, a);
    check("skip_prime", 64'(a), 64'b0001);
    req = '0;
    next_cycle();
    req = 4'b1001;
    wait_ack(1, a);
    check("skip_first", 64'(a), 64'b1000);
    req[3] = 1'b0;
    wait_ack(1, a);
    check("skip_second", 64'(a), 64'b0001);
    req = '0;
    next_cycle();

    // ---------------- read latency L=3 on second instance ----------------
    do_reset();
    next_cycle();                               // cycle 0
    req_we3 = '0;
    req_addr3[0 +: A] = 10'h7F;
    req3 = 4'b0001;
    next_cycle();                               // cycle 1
    check("rd3_re", 64'(re3), 64'h1);
    check("rd3_raddr", 64'(raddr3), 64'h7F);
    next_cycle();                               // cycle 2
    check("rd3_ack_c2", 64'(ack3), 64'h0);
    next_cycle();                               // cycle 3
    check("rd3_ack_c3", 64'(ack3), 64'h0);
    next_cycle();                               // cycle 4
    rdata3 = 32'hA5A5A5A5;
    check("rd3_ack_c4", 64'(ack3), 64'h0);
    next_cycle();                               // cycle 5
    rdata3 = 32'h0BAD_0BAD;
    check("rd3_ack", 64'(ack3), 64'b0001);
    check("rd3_ack_rdata", 64'(ack_rdata3), 64'hA5A5A5A5);
    req3 = '0;
    next_cycle();                               // cycle 6
    check("rd3_ack_c6", 64'(ack3), 64'h0);
    check("rd3_busy_c6", 64'(busy3), 64'h0);

    // ---------------- reset mid-read, then re-arbitration ----------------
    do_reset();
    rdata3 = 32'hC0FFEE00;
    next_cycle();                               // cycle 0
    req_addr3[1*A +: A] = 10'h55;
    req3 = 4'b0010;
    next_cycle();                               // cycle 1: RE
    next_cycle();                               // cycle 2: WAIT_RD
    check("mid_busy_before", 64'(busy3), 64'h1);
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_busy", 64'(busy3), 64'h0);
    check("mid_ack", 64'(ack3), 64'h0);
    check("mid_we_re", 64'({we3, re3}), 64'h0);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    wait_ack(3, a);
    check("mid_rearb_ack", 64'(a), 64'b0010);
    check("mid_rearb_rdata", 64'(ack_rdata3), 64'hC0FFEE00);
    req3 = '0;
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      next_cycle();
      if (ack3 != '0) extra++;
    end
    check("mid_single_ack", 64'(extra), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/testdrive_virtual_slave_arbiter.md
Name: testdrive_virtual_slave_arbiter

Overview:
- Shares one register-style slave port between C_PORTS requesters.
- The slave port carries registered WE/WADDR/WDATA for writes, RE/RADDR for reads, and RDATA returning a fixed number of cycles later.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between software-facing bus adapters and a user register bank, in the same place a virtual slave drives that bank.

Parameters:
- C_PORTS, 4, number of requesters (2..16).
- C_ADDR_BITS, 10, slave word-address width.
- C_READ_LATENCY, 1, cycles from the RE cycle to the cycle RDATA is valid (>=1).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  reset; asynchronous assert, active-low.
- REQ  in  C_PORTS  per-requester request, held until ACK.
- REQ_WE  in  C_PORTS  per-requester op: 1=write, 0=read; stable while REQ.
- REQ_ADDR  in  C_PORTS*C_ADDR_BITS  packed addresses; port i at [i*C_ADDR_BITS +: C_ADDR_BITS].
- REQ_WDATA  in  C_PORTS*32  packed write data; port i at [i*32 +: 32].
- ACK  out  C_PORTS  one-cycle completion pulse, one-hot.
- ACK_RDATA  out  32  read data, valid while ACK is high for a read.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- WE  out  1  slave write strobe.
- WADDR  out  C_ADDR_BITS  slave write address.
- WDATA  out  32  slave write data.
- RE  out  1  slave read strobe.
- RADDR  out  C_ADDR_BITS  slave read address.
- RDATA  in  32  slave read data.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, rr pointer=0, latency counter=0. Assertion is immediate and asynchronous, including mid-transaction: any pending ACK is dropped, RE/WE go to 0, and the aborted transaction is never issued or acknowledged.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE, no REQ bit set: stay in IDLE.
- IDLE, any REQ bit set: select winner g, the first set bit scanning upward from the pointer with wrap. Latch g, op, addr and wdata. Go to ISSUE.
- ISSUE, write: WE=1, WADDR/WDATA = latched values, ACK[g]=1 in the same cycle. Pointer <= (g+1) mod C_PORTS. Go to IDLE.
- ISSUE, read: RE=1, RADDR = latched address. Pointer <= (g+1) mod C_PORTS. Counter <= C_READ_LATENCY. Go to WAIT_RD.
- WAIT_RD: decrement the counter. In the cycle the counter equals 1, capture RDATA into ACK_RDATA and go to DONE.
- DONE: ACK[g]=1 with ACK_RDATA valid. Go to IDLE.
- WE and RE are single-cycle pulses and are never both high.
- WADDR, WDATA and RADDR hold their last values between transactions.
- ACK_RDATA holds its last captured read value; writes do not alter it.
- Latency, write: REQ first sampled at the end of cycle 0 -> WE and ACK in cycle 1.
- Latency, read: RE in cycle 1, RDATA sampled in cycle 1+L, ACK in cycle 2+L.
- Requester protocol: in the cycle after ACK, REQ is either dropped or presents a new request. The arbiter re-samples only in IDLE, so a stale REQ is never re-granted; the FSM is in IDLE exactly when that updated REQ is sampled.
- Back-to-back throughput: one write per 2 cycles; one read per L+3 cycles.
- Simultaneous requests: exactly one is granted per arbitration; losing requesters wait with REQ held and no ACK.
- Pointer wrap: after granting port C_PORTS-1, the pointer returns to 0.
- Counter width: $clog2(C_READ_LATENCY+1).

Decomposition:
- Package testdrive_virtual_slave_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RD, DONE), 2 bits;
  - the data width constant 32;
  - a function that computes the counter width.
- One sub-module, testdrive_rr_arbiter (combinational): inputs REQ and pointer; outputs a one-hot grant and the grant index. Parameterised by C_PORTS.

Test Plan:
- Single write: port 2 writes addr 0x15, data 0xDEADBEEF -> cycle 1: WE=1, WADDR=0x15, WDATA=0xDEADBEEF, ACK=4'b0100; RE stays 0.
- Single read, L=1: port 0 reads addr 0x3; slave returns 0x12345678 in cycle 2 -> RE=1, RADDR=0x3 in cycle 1; ACK=4'b0001 with ACK_RDATA=0x12345678 in cycle 3; BUSY high for cycles 1-3.
- Round-robin fairness: all 4 ports issue continuous writes -> grant order 0,1,2,3,0,1; no port is granted twice before every other requesting port has been granted.
- Pointer skip: pointer=1 after granting 0; only ports 0 and 3 request -> 3 is granted, then 0.
- Read latency L=3: read addr 0x7F; RDATA=0xA5A5A5A5 valid only in cycle 4 -> ACK in cycle 5 with 0xA5A5A5A5; a wrong value is driven on RDATA in other cycles and must not be captured.
- Reset mid-read: assert nRST=0 during WAIT_RD -> ACK, RE, WE and BUSY go to 0 immediately (asynchronously). After release, with REQ still held on port 1, the read is re-arbitrated from pointer 0 and acknowledged exactly once.
